// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU and writeback constants, PPP encodings and helpers
package alu_pkg;
    localparam int DW     = 64;
    localparam int REG_AW = 5;

    localparam logic [0:2] PPP_ALL   = 3'b000;
    localparam logic [0:2] PPP_UPPER = 3'b001;
    localparam logic [0:2] PPP_LOWER = 3'b010;
    localparam logic [0:2] PPP_EVEN  = 3'b011;
    localparam logic [0:2] PPP_ODD   = 3'b100;

    localparam logic [0:5] FN_VAND = 6'd0;
    localparam logic [0:5] FN_VOR  = 6'd1;
    localparam logic [0:5] FN_VXOR = 6'd2;
    localparam logic [0:5] FN_VNOT = 6'd3;
    localparam logic [0:5] FN_VADD = 6'd4;
    localparam logic [0:5] FN_VSUB = 6'd5;
    localparam logic [0:5] FN_VSLL = 6'd6;
    localparam logic [0:5] FN_VSRL = 6'd7;

    function automatic logic ppp_legal(input logic [0:2] ppp);
        return ppp <= PPP_ODD;
    endfunction
endpackage

// File: rtl/ppp_merge.sv
// ppp_merge: byte-select merge of an ALU result into the old rD contents under a PPP code
module ppp_merge
    import alu_pkg::*;
(
    input  logic [0:DW-1] result,
    input  logic [0:DW-1] old,
    input  logic [0:2]    ppp,
    output logic [0:DW-1] merged,
    output logic          legal
);
    logic [0:7] sel;

    always_comb begin
        sel = ppp == PPP_ALL   ? 8'hFF :
              ppp == PPP_UPPER ? 8'hF0 :
              ppp == PPP_LOWER ? 8'h0F :
              ppp == PPP_EVEN  ? 8'hAA :
              ppp == PPP_ODD   ? 8'h55 : 8'h00;
        legal = ppp_legal(ppp);
    end

    for (genvar g = 0; g < 8; g++) begin : g_byte
        assign merged[8*g +: 8] = sel[g] ? result[8*g +: 8] : old[8*g +: 8];
    end
endmodule

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: PPP merge feeding a 2-entry register-file write buffer with forwarding lookup
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = REG_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [0:DW-1] in_result,
    input  logic [0:DW-1] in_rd_old,
    input  logic [0:AW-1] in_rd_addr,
    input  logic [0:2]    in_ppp,
    input  logic          in_wr_en,
    input  logic          flush,
    input  logic          rf_ready,
    output logic          rf_wr_en,
    output logic [0:AW-1] rf_wr_addr,
    output logic [0:DW-1] rf_wr_data,
    input  logic [0:AW-1] fwd_req_addr,
    output logic          fwd_hit,
    output logic [0:DW-1] fwd_data,
    output logic          ppp_err
);
    logic [0:AW-1] mem_addr [DEPTH];
    logic [0:DW-1] mem_data [DEPTH];
    logic          head, tail;
    logic [1:0]    count;
    logic [0:DW-1] merged;
    logic          legal, accept, push, pop, young, hit_y, hit_o;

    ppp_merge u_merge (
        .result (in_result),
        .old    (in_rd_old),
        .ppp    (in_ppp),
        .merged (merged),
        .legal  (legal)
    );

    always_comb begin
        in_ready   = rst_n && !flush && count < 2'd2;
        accept     = in_valid && in_ready;
        push       = accept && in_wr_en && legal;
        rf_wr_en   = count != 2'd0;
        pop        = rf_wr_en && rf_ready;
        rf_wr_addr = mem_addr[head];
        rf_wr_data = mem_data[head];
        // the slot just behind tail always holds the youngest entry
        young      = ~tail;
        hit_y      = count != 2'd0 && mem_addr[young] == fwd_req_addr;
        hit_o      = count == 2'd2 && mem_addr[head] == fwd_req_addr;
        fwd_hit    = hit_y || hit_o;
        fwd_data   = hit_y ? mem_data[young] : hit_o ? mem_data[head] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr[i] <= '0;
                mem_data[i] <= '0;
            end
            head    <= 1'b0;
            tail    <= 1'b0;
            count   <= 2'd0;
            ppp_err <= 1'b0;
        end else begin
            ppp_err <= accept && !legal;
            if (flush) begin
                head  <= 1'b0;
                tail  <= 1'b0;
                count <= 2'd0;
            end else begin
                if (push) begin
                    mem_addr[tail] <= in_rd_addr;
                    mem_data[tail] <= merged;
                    tail           <= ~tail;
                end
                if (pop)
                    head <= ~head;
                count <= count + 2'(push) - 2'(pop);
            end
        end
    end
endmodule

// File: doc/alu_wb_stage.md
# alu_wb_stage

Writeback stage directly downstream of the vector ALU. Accepts each ALU result (`ALU_out`) with its destination register and participation field (PPP). Merges the selected bytes into the prior contents of rD. Buffers up to two merged writes in a 2-entry FIFO in front of the register-file write port, and offers a forwarding lookup over the pending writes.

## Interface
Parameters:
- `DEPTH`, 2, buffer entries (fixed at 2; other values unsupported)
- `AW`, 5, register address width

Ports (big-endian bit numbering throughout: bit 0 is the MSB; byte k is bits [8k:8k+7]):
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: a result is presented.
- `in_ready` out 1: the stage can accept.
- `in_result` in [0:63]: ALU output.
- `in_rd_old` in [0:63]: current rD contents.
- `in_rd_addr` in [0:AW-1]: destination register.
- `in_ppp` in [0:2]: participation field.
- `in_wr_en` in 1: the instruction writes rD.
- `flush` in 1: discard all buffered writes.
- `rf_ready` in 1: the register-file port accepts a write this cycle.
- `rf_wr_en` out 1, `rf_wr_addr` out [0:AW-1], `rf_wr_data` out [0:63]: register-file write port.
- `fwd_req_addr` in [0:AW-1]: forwarding lookup address.
- `fwd_hit` out 1, `fwd_data` out [0:63]: forwarding result.
- `ppp_err` out 1: one-cycle pulse flagging an illegal PPP.

## Operation
- **PPP merge.** Bytes where PPP selects take the byte from `in_result`; all other bytes take the byte from `in_rd_old`.
  - 000: all 8 bytes.
  - 001: upper half, bytes 0–3 (bits 0:31).
  - 010: lower half, bytes 4–7 (bits 32:63).
  - 011: even bytes 0, 2, 4, 6.
  - 100: odd bytes 1, 3, 5, 7.
  - 101–111: illegal.
- **Accept.** A transfer occurs when `in_valid && in_ready`.
  - If `in_wr_en=1` and PPP is legal, the merged data and address are enqueued at the tail.
  - If `in_wr_en=0`, the transfer is consumed and nothing is enqueued.
  - If PPP is illegal, the transfer is consumed, nothing is enqueued, and `ppp_err=1` in the following cycle.
- **Drain.**
  - `rf_wr_en=1` whenever count>0.
  - `rf_wr_addr` / `rf_wr_data` come from the head entry.
  - The head pops on the edge where `rf_wr_en && rf_ready`.
  - Output data stays stable while `rf_ready=0`.
- **Ready and count.**
  - `in_ready = rst_n && !flush && count<2`.
  - `in_ready` does not depend on `rf_ready`.
  - An enqueue and a pop in the same cycle leave count unchanged; at count=1 the new entry becomes the head on the next cycle.
- **Flush.** Count goes to 0 at the edge; no enqueue happens in that cycle; a pop in that cycle is also discarded.
- **Forwarding** (combinational).
  - Search the valid entries for `fwd_req_addr`; the youngest (tail) match wins.
  - `fwd_hit=0` and `fwd_data=0` when there is no match.
  - The incoming transfer is not searched.
- **Ordering.** Writes reach the register file in acceptance order. Duplicate addresses are legal.

## Timing
- **Reset.** Asserting `rst_n` low clears everything immediately, regardless of `clk`:
  - count=0, head and tail pointers 0.
  - `rf_wr_en=0`, `rf_wr_addr=0`, `rf_wr_data=0` (the storage array is cleared too).
  - `ppp_err=0`, `fwd_hit=0`, `fwd_data=0`.
  - `in_ready=0` while low; `in_ready=1` in the first cycle after release.
  - Reset mid-operation drops buffered writes; no partial write is emitted.
- **Latency.** A result accepted at edge N with the buffer empty appears on `rf_wr_*` in cycle N+1.
- **Throughput.** One write per cycle while `rf_ready=1`.
- **Backpressure.** With `rf_ready=0`, two accepts fill the buffer, then `in_ready=0`. `in_ready` returns to 1 the cycle after the first pop.
- **Pointers.** 1-bit head and tail, wrapping 1→0. Count is 2 bits, range 0–2.

## Structure
- Shared package `alu_pkg` holds:
  - PPP encodings (`PPP_ALL`, `PPP_UPPER`, `PPP_LOWER`, `PPP_EVEN`, `PPP_ODD`);
  - the data width of 64;
  - the register address width;
  - the function-code constants already shared with the ALU.
- Sub-module `ppp_merge`: combinational function of (result, old, ppp) → (merged, legal).
- FIFO storage, pointers, forwarding search and error pulse stay in `alu_wb_stage`.

## Test plan
Common stimulus unless stated: result=FFFFFFFF_11111110 (VADD, WW=10, of FFFFFFFF_FFFFFFFF and 00000000_11111111), old=01234567_89ABCDEF, rd=7, wr_en=1, `rf_ready=1`.
- **Merge, all PPP codes.** Required `rf_wr_data`, one cycle after accept:
  - 000 → FFFFFFFF_11111110
  - 001 → FFFFFFFF_89ABCDEF
  - 010 → 01234567_11111110
  - 011 → FF23FF67_11AB11EF
  - 100 → 01FF45FF_8911CD10
- **Illegal PPP.** PPP=110 → nothing is written and `ppp_err` pulses for exactly one cycle. PPP=000 with wr_en=0 → no write and no error.
- **Backpressure.** Hold `rf_ready=0`, accept rd=3 then rd=3 with a different result.
  - Expect `in_ready=0` after the second accept.
  - Lookup on address 3 → `fwd_hit=1` with the second result.
  - Release `rf_ready` → both writes emerge in order on consecutive cycles.
- **Simultaneous accept and pop.** At count=1, accept while `rf_ready=1` → count stays 1, and the next cycle shows the new entry as head.
- **Flush.** Flush with two pending entries → no writes follow and `fwd_hit=0`. An input presented in the flush cycle is not accepted.
- **Reset mid-drain.** Assert `rst_n` low with two pending entries and `rf_ready=0` → `rf_wr_en` drops to 0 immediately; after release nothing is written and `in_ready=1`.
